// File: rtl/apb_ws_slave.sv
// APB byte-memory slave with a runtime wait-state count, sampled at setup, and
// PSLVERR on out-of-range addresses. All APB response outputs are registered.
module apb_ws_slave #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 64,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [3:0]            ws_cfg,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr,
  output logic                  xfer_done,
  output logic [ERR_CNT_W-1:0]  err_cnt
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = MEM_DEPTH[ADDR_WIDTH:0];
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  ferr_q, ferr_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  xfer_done_q, xfer_done_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

  logic complete_s;
  logic cur_err_s;
  logic nxt_err_s;

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= DEPTH_L);
  endfunction

  assign cur_err_s = ferr_q | out_of_range(addr_q);

  // Transfer FSM, memory commit, error counting and next-cycle response outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    ferr_d     = ferr_q;
    mem_d      = mem_q;
    err_cnt_d  = err_cnt_q;
    complete_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (psel && !penable) begin
          addr_d  = paddr;
          wr_d    = pwrite;
          wdata_d = pwdata;
          cnt_d   = ws_cfg;
          ferr_d  = 1'b0;
          state_d = (ws_cfg == 4'd0) ? ST_RESP : ST_WAIT;
        end else if (psel && penable) begin
          // Access phase without a setup: answer with an error, touch nothing.
          wr_d    = pwrite;
          ferr_d  = 1'b1;
          state_d = ST_RESP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!psel) begin
          state_d = ST_IDLE;
        end else if (penable) begin
          if (cnt_q == 4'd1) begin
            state_d = ST_RESP;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (!psel) begin
          state_d = ST_IDLE;
        end else if (penable && pready_q) begin
          complete_s = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (complete_s && wr_q && !cur_err_s) begin
      mem_d[addr_q[IDX_W-1:0]] = wdata_q;
    end else begin
      mem_d = mem_q;
    end

    if (complete_s && cur_err_s && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_ONE;
    end else begin
      err_cnt_d = err_cnt_q;
    end

    // Memory cannot change while entering or sitting in RESP, so read data is stable.
    nxt_err_s   = ferr_d | out_of_range(addr_d);
    xfer_done_d = complete_s;
    pready_d    = (state_d == ST_RESP);
    pslverr_d   = pready_d & nxt_err_s;
    if (pready_d && !wr_d && !nxt_err_s) begin
      prdata_d = mem_q[addr_d[IDX_W-1:0]];
    end else begin
      prdata_d = '0;
    end
  end

  // State, latched transfer fields, memory and registered outputs.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      ferr_q      <= 1'b0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      prdata_q    <= '0;
      xfer_done_q <= 1'b0;
      err_cnt_q   <= '0;
      mem_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      ferr_q      <= ferr_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      prdata_q    <= prdata_d;
      xfer_done_q <= xfer_done_d;
      err_cnt_q   <= err_cnt_d;
      mem_q       <= mem_d;
    end
  end

  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign prdata    = prdata_q;
  assign xfer_done = xfer_done_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_apb_ws_slave.sv
// Scoreboard bench for apb_ws_slave: stimulus queues expected {pslverr,prdata},
// a negedge monitor pops and compares on every completed access.
module tb_apb_ws_slave;

  logic       pclk;
  logic       presetn;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [3:0] ws_cfg;
  logic       pready;
  logic [7:0] prdata;
  logic       pslverr;
  logic       xfer_done;
  logic [7:0] err_cnt;

  int checks    = 0;
  int failures  = 0;
  int exp_done  = 0;
  int done_seen = 0;
  int exp_err   = 0;
  logic [8:0] sb_q [$];

  apb_ws_slave dut (
    .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .ws_cfg(ws_cfg),
    .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .xfer_done(xfer_done), .err_cnt(err_cnt)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare each completed access against the head of the scoreboard.
  always @(negedge pclk) begin
    logic [8:0] e;
    if (presetn && psel && penable && pready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pready actual=1 expected=0 t=%0t", $time);
      end else begin
        e = sb_q.pop_front();
        chk("prdata", {24'd0, prdata}, {24'd0, e[7:0]});
        chk("pslverr", {31'd0, pslverr}, {31'd0, e[8]});
      end
    end
    if (presetn && xfer_done) done_seen++;
  end

  // Full transfer starting at posedge+1; returns at posedge+1 after the completion edge.
  task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                      input logic [3:0] ws, input logic [7:0] erd, input logic eerr);
    int n;
    sb_q.push_back({eerr, erd});
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; ws_cfg = ws;
    @(posedge pclk); #1;
    penable = 1'b1; pwrite = ~w; paddr = a ^ 8'h3C; pwdata = ~d; ws_cfg = ~ws;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (!pready && n < 20);
    chk("access_cycles", n, ws + 1);
    @(posedge pclk); #1;
    exp_done++;
    if (eerr && exp_err < 255) exp_err++;
  endtask

  task automatic idle(input int cyc);
    psel = 1'b0; penable = 1'b0;
    repeat (cyc) begin
      @(posedge pclk); #1;
    end
  endtask

  initial begin
    time t0;
    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 8'h00; ws_cfg = 4'd0;
    #2;
    chk("rst_pready", {31'd0, pready}, 32'd0);
    chk("rst_prdata", {24'd0, prdata}, 32'd0);
    chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    chk("rst_xfer_done", {31'd0, xfer_done}, 32'd0);
    @(negedge pclk); presetn = 1'b1;
    @(posedge pclk); #1;

    // Zero-wait write/read, plus the last valid location.
    xfer(1'b1, 8'h05, 8'hAA, 4'd0, 8'h00, 1'b0);
    xfer(1'b0, 8'h05, 8'h00, 4'd0, 8'hAA, 1'b0);
    xfer(1'b1, 8'h3F, 8'h3C, 4'd0, 8'h00, 1'b0);
    xfer(1'b0, 8'h3F, 8'h00, 4'd0, 8'h3C, 1'b0);
    idle(1);

    // Three wait states; location is empty beforehand.
    xfer(1'b0, 8'h10, 8'h00, 4'd0, 8'h00, 1'b0);
    xfer(1'b1, 8'h10, 8'hBB, 4'd3, 8'h00, 1'b0);
    idle(1);
    xfer(1'b0, 8'h10, 8'h00, 4'd2, 8'hBB, 1'b0);
    idle(1);
    chk("done_cnt_a", done_seen, exp_done);

    // Out-of-range write and read.
    xfer(1'b1, 8'h7F, 8'hFF, 4'd0, 8'h00, 1'b1);
    xfer(1'b0, 8'h7F, 8'h00, 4'd0, 8'h00, 1'b1);
    idle(1);
    chk("err_cnt_2", {24'd0, err_cnt}, 32'd2);
    chk("done_cnt_b", done_seen, exp_done);

    // Abort during wait states.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h20; pwdata = 8'h11; ws_cfg = 4'd5;
    @(posedge pclk); #1;
    penable = 1'b1;
    repeat (2) begin
      @(negedge pclk);
      chk("abort_pready", {31'd0, pready}, 32'd0);
      @(posedge pclk); #1;
    end
    idle(3);
    chk("abort_done", done_seen, exp_done);
    xfer(1'b0, 8'h20, 8'h00, 4'd0, 8'h00, 1'b0);
    idle(1);

    // Async reset in the middle of a waited read.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h05; ws_cfg = 4'd4;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #2;
    presetn = 1'b0;
    #1;
    chk("mid_rst_pready", {31'd0, pready}, 32'd0);
    chk("mid_rst_prdata", {24'd0, prdata}, 32'd0);
    chk("mid_rst_pslverr", {31'd0, pslverr}, 32'd0);
    chk("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    exp_err = 0;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; presetn = 1'b1;
    @(posedge pclk); #1;
    xfer(1'b0, 8'h05, 8'h00, 4'd0, 8'h00, 1'b0);
    xfer(1'b0, 8'h10, 8'h00, 4'd1, 8'h00, 1'b0);
    idle(1);

    // 260 back-to-back errored writes; err_cnt must saturate.
    t0 = $time;
    for (int i = 0; i < 260; i++) begin
      xfer(1'b1, 8'(64 + (i % 192)), 8'(i), 4'd0, 8'h00, 1'b1);
    end
    chk("b2b_time", 32'($time - t0), 32'(260 * 20));
    idle(1);
    chk("err_cnt_sat", {24'd0, err_cnt}, 32'(exp_err));
    chk("done_cnt_c", done_seen, exp_done);
    xfer(1'b0, 8'h00, 8'h00, 4'd0, 8'h00, 1'b0);
    xfer(1'b0, 8'h3F, 8'h00, 4'd0, 8'h00, 1'b0);
    idle(1);

    // Access phase with no setup: forced error, counter stays saturated.
    begin
      int n;
      sb_q.push_back({1'b1, 8'h00});
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h02; pwdata = 8'h55;
      n = 0;
      do begin
        @(negedge pclk);
        n++;
      end while (!pready && n < 20);
      chk("forced_latency", n, 2);
      @(posedge pclk); #1;
      exp_done++;
    end
    idle(1);
    chk("err_cnt_hold", {24'd0, err_cnt}, 32'd255);
    xfer(1'b0, 8'h02, 8'h00, 4'd0, 8'h00, 1'b0);
    idle(2);
    chk("done_cnt_d", done_seen, exp_done);
    chk("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
